// File: rtl/vdec_pkg.sv
// Shared constants and FSM state type for the Viterbi symbol-error counter.
// Generator polynomials are octal with the MSB tapping the current input bit.
package vdec_pkg;

  localparam logic [8:0] G13_0 = 9'o557;
  localparam logic [8:0] G13_1 = 9'o663;
  localparam logic [8:0] G13_2 = 9'o711;
  localparam logic [8:0] G12_0 = 9'o561;
  localparam logic [8:0] G12_1 = 9'o753;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/vdec_conv_enc.sv
// K=9 convolutional encoder: 8-bit history plus the current bit, one parity
// output per generator packed in GENS (generator 0 in the low 9 bits).
module vdec_conv_enc
  import vdec_pkg::*;
#(
  parameter int unsigned           N_GEN = 2,
  parameter logic [9*N_GEN-1:0]    GENS  = {G12_1, G12_0}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift,
  input  logic             din,
  output logic [N_GEN-1:0] code
);

  // sr[7] is the most recent past bit, sr[0] the oldest
  logic [7:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (clr) begin
      sr <= '0;
    end else if (shift) begin
      sr <= {din, sr[7:1]};
    end
  end

  always_comb begin
    code = '0;
    for (int unsigned g = 0; g < N_GEN; g++) begin
      code[g] = ^(GENS[g*9 +: 9] & {din, sr});
    end
  end

endmodule

// File: rtl/vdec_ser_calc.sv
// Symbol-error counter: re-encodes decoded bits (optionally XOR UE-mask code),
// compares against hard decisions of buffered soft symbols, counts mismatches.
module vdec_ser_calc
  import vdec_pkg::*;
#(
  parameter int unsigned MAX_BITS     = 32,
  parameter int unsigned SOFT_W       = 6,
  parameter int unsigned SYM_PER_WORD = 4,
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned ACC_W        = 8,
  parameter int unsigned MASK_W       = 16,
  parameter int unsigned IDX_W        = 7
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             abort,
  output logic                             busy,
  output logic                             done,
  input  logic                             rate_sel,
  input  logic [$clog2(MAX_BITS+1)-1:0]    n_bits,
  input  logic [MAX_BITS-1:0]              dec_bits,
  input  logic                             mask_en,
  input  logic [MASK_W-1:0]                ue_mask,
  input  logic [ADDR_W-1:0]                base_addr,
  output logic                             rd_req,
  output logic [ADDR_W-1:0]                rd_addr,
  input  logic                             rd_ack,
  input  logic [SYM_PER_WORD*SOFT_W-1:0]   rd_data,
  output logic [IDX_W-1:0]                 punc_idx,
  input  logic                             punc,
  output logic [ACC_W-1:0]                 ser_acc,
  output logic [ACC_W-1:0]                 sym_cnt
);

  localparam int unsigned SI_W = (SYM_PER_WORD > 1) ? $clog2(SYM_PER_WORD) : 1;
  localparam int unsigned BI_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
  localparam int unsigned MI_W = (MASK_W > 1) ? $clog2(MASK_W) : 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  state_t                  state;
  logic [IDX_W-1:0]        k;
  logic [IDX_W-1:0]        last_k;
  logic [1:0]              phase;
  logic [BI_W-1:0]         bit_idx;
  logic [1:0]              buf_cnt;
  logic                    head;
  logic [SI_W-1:0]         sym_idx;
  // Only the hard decisions of each word are kept; the soft LSBs are not needed
  logic [SYM_PER_WORD-1:0] hard_q [2];
  logic [SYM_PER_WORD-1:0] hard_in;
  logic                    soft_unused;

  logic [4:0]              info_code;
  logic [1:0]              mask_code;
  logic                    info_in;
  logic                    mask_in;
  logic                    info_coded;
  logic                    mask_coded;
  logic                    coded;
  logic                    soft_msb;
  logic [IDX_W-2:0]        m_idx;

  logic                    avail;
  logic                    adv;
  logic                    cmp;
  logic                    finish;
  logic                    pop;
  logic                    push;
  logic                    issue;
  logic                    start_ok;
  logic                    last_phase;
  logic                    shift_info;
  logic                    shift_mask;
  int unsigned             len_i;
  int unsigned             buffered_i;
  int unsigned             remaining_i;

  assign punc_idx    = k;
  assign soft_unused = ^rd_data;

  always_comb begin
    hard_in = '0;
    for (int unsigned i = 0; i < SYM_PER_WORD; i++) begin
      hard_in[i] = rd_data[i*SOFT_W + SOFT_W - 1];
    end
  end

  always_comb begin
    len_i  = 32'(n_bits) * (rate_sel ? 32'd2 : 32'd3);
    last_k = IDX_W'(len_i - 32'd1);

    info_in = dec_bits[bit_idx];
    m_idx   = k[IDX_W-1:1];
    mask_in = (32'(m_idx) < MASK_W) ? ue_mask[m_idx[MI_W-1:0]] : 1'b0;

    if (rate_sel) begin
      last_phase = (phase == 2'd1);
      info_coded = phase[0] ? info_code[4] : info_code[3];
    end else begin
      last_phase = (phase == 2'd2);
      case (phase)
        2'd0:    info_coded = info_code[0];
        2'd1:    info_coded = info_code[1];
        default: info_coded = info_code[2];
      endcase
    end
    mask_coded = k[0] ? mask_code[1] : mask_code[0];
    coded      = info_coded ^ (mask_en & mask_coded);
    soft_msb   = hard_q[head][sym_idx];

    avail    = (buf_cnt != 2'd0);
    adv      = (state == ST_RUN) && !abort && (punc || avail);
    cmp      = adv && !punc;
    finish   = adv && (k == last_k);
    pop      = cmp && (sym_idx == SI_W'(SYM_PER_WORD - 1));
    push     = (state == ST_RUN) && !abort && rd_req && rd_ack;
    start_ok = (state == ST_IDLE) && !busy && start && !abort;

    // Never fetch more symbols than coded positions remain, so an unpunctured
    // block reads exactly the words it needs.
    buffered_i  = 32'(buf_cnt) * SYM_PER_WORD - 32'(sym_idx);
    remaining_i = 32'(last_k) - 32'(k) + 32'd1;
    issue = (state == ST_RUN) && !abort && !rd_req && !finish &&
            (buf_cnt != 2'd2) && (buffered_i < remaining_i);

    shift_info = adv && last_phase;
    shift_mask = adv && k[0];
  end

  vdec_conv_enc #(
    .N_GEN (5),
    .GENS  ({G12_1, G12_0, G13_2, G13_1, G13_0})
  ) u_info_enc (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_ok),
    .shift (shift_info),
    .din   (info_in),
    .code  (info_code)
  );

  vdec_conv_enc #(
    .N_GEN (2),
    .GENS  ({G12_1, G12_0})
  ) u_mask_enc (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_ok),
    .shift (shift_mask),
    .din   (mask_in),
    .code  (mask_code)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      hard_q[head ^ buf_cnt[0]] <= hard_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_req  <= 1'b0;
      rd_addr <= '0;
      ser_acc <= '0;
      sym_cnt <= '0;
      k       <= '0;
      phase   <= '0;
      bit_idx <= '0;
      buf_cnt <= '0;
      head    <= 1'b0;
      sym_idx <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state  <= ST_IDLE;
        busy   <= 1'b0;
        rd_req <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (done) begin
              busy <= 1'b0;
            end
            if (start_ok) begin
              state   <= ST_RUN;
              busy    <= 1'b1;
              ser_acc <= '0;
              sym_cnt <= '0;
              k       <= '0;
              phase   <= '0;
              bit_idx <= '0;
              buf_cnt <= '0;
              head    <= 1'b0;
              sym_idx <= '0;
              rd_req  <= 1'b1;
              rd_addr <= base_addr;
            end
          end

          ST_RUN: begin
            if (push) begin
              rd_req  <= 1'b0;
              rd_addr <= rd_addr + 1'b1;
            end else if (issue) begin
              rd_req <= 1'b1;
            end

            case ({push, pop})
              2'b10:   buf_cnt <= buf_cnt + 2'd1;
              2'b01:   buf_cnt <= buf_cnt - 2'd1;
              default: buf_cnt <= buf_cnt;
            endcase

            if (cmp) begin
              sym_idx <= pop ? '0 : sym_idx + 1'b1;
              if (pop) begin
                head <= ~head;
              end
              if (sym_cnt != ACC_MAX) begin
                sym_cnt <= sym_cnt + 1'b1;
              end
              if ((coded != soft_msb) && (ser_acc != ACC_MAX)) begin
                ser_acc <= ser_acc + 1'b1;
              end
            end

            if (adv) begin
              k <= k + 1'b1;
              if (last_phase) begin
                phase   <= '0;
                bit_idx <= bit_idx + 1'b1;
              end else begin
                phase <= phase + 2'd1;
              end
            end

            if (finish) begin
              state <= ST_DRAIN;
            end
          end

          ST_DRAIN: begin
            // A word landing here is dropped; the block is already fully compared
            if (!rd_req || rd_ack) begin
              rd_req <= 1'b0;
              state  <= ST_IDLE;
              done   <= 1'b1;
            end
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vdec_ser_calc.sv
// Randomised scoreboard bench for vdec_ser_calc with a behavioural
// convolutional-code reference model and a second 4-bit-counter instance.
`timescale 1ns/1ps
module tb_vdec_ser_calc;

  localparam int MAX_BITS = 32;
  localparam int SOFT_W   = 6;
  localparam int SPW      = 4;
  localparam int ADDR_W   = 9;
  localparam int MASK_W   = 16;
  localparam int IDX_W    = 7;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start, abort;
  logic                    rate_sel;
  logic [5:0]              n_bits;
  logic [MAX_BITS-1:0]     dec_bits;
  logic                    mask_en;
  logic [MASK_W-1:0]       ue_mask;
  logic [ADDR_W-1:0]       base_addr;
  logic                    rd_ack;
  logic [SPW*SOFT_W-1:0]   rd_data;
  logic                    punc;

  logic                    busy, done, rd_req;
  logic [ADDR_W-1:0]       rd_addr;
  logic [IDX_W-1:0]        punc_idx;
  logic [7:0]              ser_acc, sym_cnt;

  logic                    busy4, done4, rd_req4;
  logic [ADDR_W-1:0]       rd_addr4;
  logic [IDX_W-1:0]        punc_idx4;
  logic [3:0]              ser_acc4, sym_cnt4;

  always #5 clk = ~clk;

  vdec_ser_calc u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .rate_sel(rate_sel), .n_bits(n_bits), .dec_bits(dec_bits), .mask_en(mask_en),
    .ue_mask(ue_mask), .base_addr(base_addr), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ack(rd_ack), .rd_data(rd_data), .punc_idx(punc_idx), .punc(punc),
    .ser_acc(ser_acc), .sym_cnt(sym_cnt)
  );

  vdec_ser_calc #(.ACC_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy4), .done(done4),
    .rate_sel(rate_sel), .n_bits(n_bits), .dec_bits(dec_bits), .mask_en(mask_en),
    .ue_mask(ue_mask), .base_addr(base_addr), .rd_req(rd_req4), .rd_addr(rd_addr4),
    .rd_ack(rd_ack), .rd_data(rd_data), .punc_idx(punc_idx4), .punc(punc),
    .ser_acc(ser_acc4), .sym_cnt(sym_cnt4)
  );

  typedef struct {
    string name;
    int    ser;
    int    sym;
  } exp_t;

  exp_t          exp_q[$];
  int            vectors    = 0;
  int            miscompares = 0;
  int            done_cnt   = 0;
  int            run_reads  = 0;
  int            run_base   = 0;
  int            force_lat  = -1;
  int            punc_mode  = 0;
  logic [127:0]  punc_tab   = '0;
  logic [23:0]   mem [512];

  function automatic void chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic bit punc_at(input int k);
    if (punc_mode == 1) return (k % 4) == 3;
    if (punc_mode == 2) return punc_tab[k];
    return 1'b0;
  endfunction

  always_comb punc = punc_at(int'(punc_idx));

  // Reference: coded bit k is parity of generator taps over the info bit
  // history (plus mask code), compared against the MSB of the s-th symbol.
  function automatic void model(input bit rate, input int n, input logic [31:0] dec,
                                input bit men, input logic [15:0] msk, input int base,
                                output int ser, output int sym);
    int          r;
    int          j, p, m;
    logic [8:0]  g, gm;
    logic [23:0] w;
    bit          cb, hb;
    r   = rate ? 2 : 3;
    ser = 0;
    sym = 0;
    for (int k = 0; k < n * r; k++) begin
      if (!punc_at(k)) begin
        j = k / r;
        p = k % r;
        if (rate) g = (p == 0) ? 9'o561 : 9'o753;
        else      g = (p == 0) ? 9'o557 : (p == 1) ? 9'o663 : 9'o711;
        cb = 1'b0;
        for (int i = 0; i < 9; i++)
          if (j - i >= 0 && g[8-i]) cb ^= dec[j-i];
        if (men) begin
          m  = k / 2;
          gm = (k % 2) ? 9'o753 : 9'o561;
          for (int i = 0; i < 9; i++)
            if (m - i >= 0 && m - i < MASK_W && gm[8-i]) cb ^= msk[m-i];
        end
        w  = mem[(base + sym / SPW) % 512];
        hb = w[(sym % SPW) * SOFT_W + SOFT_W - 1];
        if (cb != hb) ser++;
        sym++;
      end
    end
  endfunction

  // Memory responder: acks each request after a latency, even if the DUT has
  // since abandoned it.
  initial begin
    int lat;
    int a;
    bit live;
    rd_ack  = 1'b0;
    rd_data = '0;
    forever begin
      @(posedge clk); #1;
      if (rd_req && !rst) begin
        lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
        a   = int'(rd_addr);
        repeat (lat) begin @(posedge clk); #1; end
        live = rd_req;
        if (live) begin
          chk("rd_addr", a, (run_base + run_reads) % 512);
          run_reads++;
        end
        rd_data = mem[a];
        rd_ack  = 1'b1;
        @(posedge clk); #1;
        rd_ack  = 1'b0;
      end
    end
  end

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, "_ser_acc"}, int'(ser_acc), e.ser > 255 ? 255 : e.ser);
          chk({e.name, "_sym_cnt"}, int'(sym_cnt), e.sym > 255 ? 255 : e.sym);
          chk({e.name, "_ser_acc4"}, int'(ser_acc4), e.ser > 15 ? 15 : e.ser);
          chk({e.name, "_sym_cnt4"}, int'(sym_cnt4), e.sym > 15 ? 15 : e.sym);
          chk({e.name, "_busy"}, int'(busy), 1);
          chk({e.name, "_lockstep"},
              int'({done4, busy4, rd_req4, rd_addr4, punc_idx4}),
              int'({done, busy, rd_req, rd_addr, punc_idx}));
        end
      end
    end
  end

  task automatic fill_mem(input int mode);
    for (int i = 0; i < 512; i++)
      mem[i] = (mode == 0) ? 24'h0 : (mode == 1) ? 24'hFFFFFF : 24'($urandom);
  endtask

  task automatic set_cfg(input bit rate, input int n, input logic [31:0] dec,
                         input bit men, input logic [15:0] msk, input int base, input int pm);
    rate_sel  = rate;
    n_bits    = 6'(n);
    dec_bits  = dec;
    mask_en   = men;
    ue_mask   = msk;
    base_addr = 9'(base);
    punc_mode = pm;
    run_base  = base;
    run_reads = 0;
  endtask

  task automatic run_block(input string name, input bit rate, input int n,
                           input logic [31:0] dec, input bit men, input logic [15:0] msk,
                           input int base, input int pm);
    exp_t e;
    int   cyc;
    int   d0;
    int   words;
    set_cfg(rate, n, dec, men, msk, base, pm);
    model(rate, n, dec, men, msk, base, e.ser, e.sym);
    e.name = name;
    exp_q.push_back(e);
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (busy && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (busy) begin
      chk({name, "_timeout"}, cyc, 0);
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
    end
    chk({name, "_done_pulses"}, done_cnt - d0, 1);
    words = (e.sym + SPW - 1) / SPW;
    if (pm == 0) chk({name, "_reads"}, run_reads, words);
    else chk({name, "_reads_range"}, int'(run_reads >= words && run_reads <= words + 2), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    set_cfg(1'b0, 16, '0, 1'b0, '0, 0, 0);
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_req", int'(rd_req), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_ser_acc", int'(ser_acc), 0);
    chk("rst_sym_cnt", int'(sym_cnt), 0);
    chk("rst_punc_idx", int'(punc_idx), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    fill_mem(0);
    run_block("T1", 1'b0, 16, 32'h0, 1'b0, 16'h0, 0, 0);
    fill_mem(1);
    run_block("T2_T6", 1'b0, 16, 32'h0, 1'b0, 16'h0, 0, 0);
    fill_mem(0);
    run_block("T3", 1'b0, 16, 32'h1, 1'b0, 16'h0, 0, 0);
    run_block("T4", 1'b1, 16, 32'h0, 1'b0, 16'h0, 0, 1);
    run_block("T5", 1'b0, 16, 32'h0, 1'b1, 16'h0001, 0, 0);

    // abort with a late ack, then a clean T1
    set_cfg(1'b0, 16, '0, 1'b0, '0, 0, 0);
    force_lat = 5;
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("T7_busy_after_abort", int'(busy), 0);
    chk("T7_rd_req_after_abort", int'(rd_req), 0);
    repeat (10) @(posedge clk);
    #1;
    chk("T7_no_done", done_cnt - d0, 0);
    chk("T7_idle_after_late_ack", int'(busy), 0);
    force_lat = -1;

    // abort wins over a simultaneous start
    #0 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    chk("abort_over_start_busy", int'(busy), 0);
    chk("abort_over_start_req", int'(rd_req), 0);
    run_block("T7_T1", 1'b0, 16, 32'h0, 1'b0, 16'h0, 0, 0);

    fill_mem(2);
    run_block("n1_r13", 1'b0, 1, $urandom, 1'b1, 16'($urandom), 7, 0);
    run_block("n1_r12", 1'b1, 1, $urandom, 1'b0, 16'h0, 100, 0);
    run_block("n32_r13", 1'b0, 32, $urandom, 1'b1, 16'($urandom), 300, 0);
    run_block("n32_r12", 1'b1, 32, $urandom, 1'b1, 16'($urandom), 450, 0);

    for (int t = 0; t < 24; t++) begin
      fill_mem(2);
      punc_tab = {$urandom, $urandom, $urandom, $urandom};
      run_block($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)),
                int'($urandom_range(1, 32)), $urandom, 1'($urandom_range(0, 1)),
                16'($urandom), int'($urandom_range(0, 480)), int'($urandom_range(0, 2)));
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
